sponge_arbiter: RTL and testbench

- Shares one Keccak `sponge` instance (SHAKE128/256 core) between NREQ sampler requesters, e.g. ExpandA, ExpandS, ExpandMask and SampleInBall.
- Grants exclusive ownership to one requester at a time and muxes that requester's absorb/squeeze signals onto the sponge.
- Flushes (resets) the sponge on every hand-over, so each owner starts from a clean state.
- Sits between the sampler FSMs and the single sponge in the keygen/sign top.

---
 rtl/sponge_arb_pkg.sv | 68 ++++++
 rtl/sponge_arbiter_rr_arbiter.sv | 74 +++++++
 rtl/sponge_arbiter.sv | 132 +++++++++++++
 tb/tb_sponge_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sponge_arb_pkg.sv
// Shared types and helpers for the sponge ownership arbiter.
// Holds the FSM state encoding, default widths and the winner-select
// functions used by rr_arbiter (round-robin and fixed-priority flavours).
package sponge_arb_pkg;

  // Widest requester set the helper functions are written for.
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  // Default configuration used by the keygen/sign top.
  localparam int DEF_NREQ          = 4;
  localparam int DEF_DATA_IN_BITS  = 64;
  localparam int DEF_DATA_OUT_BITS = 64;
  localparam int DEF_LEN_W         = $clog2(DEF_DATA_IN_BITS) + 1;
  localparam int DEF_IDX_W         = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Round-robin pick: the first requester at or after ptr (wrapping at
  // nreq) wins. Returns 0 when nobody requests; callers qualify with |req.
  function automatic logic [MAX_IDX_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int                   nreq = DEF_NREQ
  );
    logic [MAX_IDX_W-1:0] win;
    logic                 found;
    int                   idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < nreq) begin
        idx = int'(ptr) + k;
        if (idx >= nreq) begin
          idx = idx - nreq;
        end
        if (!found && req[idx[MAX_IDX_W-1:0]]) begin
          win   = idx[MAX_IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

  // Fixed-priority pick: the lowest requesting index wins.
  function automatic logic [MAX_IDX_W-1:0] fp_pick(
    input logic [MAX_REQ-1:0] req
  );
    logic [MAX_IDX_W-1:0] win;
    logic                 found;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (!found && req[k]) begin
        win   = MAX_IDX_W'(k);
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/sponge_arbiter_rr_arbiter.sv
// Winner selection for the sponge arbiter.
// Default build: round-robin with a pointer that moves one past the
// owner when its transaction is released.
// With FIXED_PRIORITY_EN defined the lowest index always wins and no
// pointer is kept.
module rr_arbiter
  import sponge_arb_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  input  logic [IDX_W-1:0] owner_idx,
  output logic [IDX_W-1:0] winner
);

  logic [MAX_REQ-1:0] req_ext;

  // Zero-extend the request vector to the width the helper functions take.
  always_comb begin
    req_ext            = '0;
    req_ext[NREQ-1:0]  = req;
  end

`ifdef FIXED_PRIORITY_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst_n, advance, owner_idx};

  // Lowest requesting index wins; nothing to remember between rounds.
  always_comb begin
    winner = IDX_W'(fp_pick(req_ext));
  end

`else

  logic [IDX_W-1:0]     ptr_q;
  logic [IDX_W-1:0]     ptr_d;
  logic [MAX_IDX_W-1:0] ptr_ext;

  // Pointer moves to one past the releasing owner, wrapping at NREQ-1.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      if (owner_idx == IDX_W'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = owner_idx + IDX_W'(1);
      end
    end
  end

  // Pointer register, cleared by reset so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Round-robin winner search starting at the pointer.
  always_comb begin
    ptr_ext              = '0;
    ptr_ext[IDX_W-1:0]   = ptr_q;
    winner               = IDX_W'(rr_pick(req_ext, ptr_ext, NREQ));
  end

`endif

endmodule

// File: rtl/sponge_arbiter.sv
// Shares one Keccak sponge between NREQ sampler requesters.
// One owner at a time gets its absorb/squeeze signals muxed onto the
// sponge; every hand-over passes through a one-cycle FLUSH that resets
// the sponge so each owner starts clean.
// Optional macro FIXED_PRIORITY_EN switches the arbitration (inside
// rr_arbiter) from round-robin to lowest-index-wins.
module sponge_arbiter
  import sponge_arb_pkg::*;
#(
  parameter int NREQ          = DEF_NREQ,
  parameter int DATA_IN_BITS  = DEF_DATA_IN_BITS,
  parameter int DATA_OUT_BITS = DEF_DATA_OUT_BITS,
  parameter int LEN_W         = $clog2(DATA_IN_BITS) + 1,
  parameter int IDX_W         = $clog2(NREQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              flush_req,
  input  logic [NREQ*DATA_IN_BITS-1:0] r_data_in,
  input  logic [NREQ-1:0]              r_in_valid,
  input  logic [NREQ-1:0]              r_in_last,
  input  logic [NREQ*LEN_W-1:0]        r_last_len,
  input  logic [NREQ-1:0]              r_out_ready,
  output logic [NREQ-1:0]              gnt,
  output logic [NREQ-1:0]              r_in_ready,
  output logic [NREQ-1:0]              r_out_valid,
  output logic [DATA_OUT_BITS-1:0]     r_data_out,
  output logic                         s_rst,
  output logic [DATA_IN_BITS-1:0]      s_data_in,
  output logic                         s_in_valid,
  output logic                         s_in_last,
  output logic [LEN_W-1:0]             s_last_len,
  output logic                         s_out_ready,
  input  logic [DATA_OUT_BITS-1:0]     s_data_out,
  input  logic                         s_out_valid,
  input  logic                         s_in_ready
);

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic [IDX_W-1:0] owner_q;
  logic [IDX_W-1:0] owner_d;
  logic [IDX_W-1:0] winner;
  logic             advance;
  logic             grant_active;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .advance   (advance),
    .owner_idx (owner_q),
    .winner    (winner)
  );

  // Ownership FSM: IDLE picks a winner, FLUSH resets the sponge, GRANT
  // holds until the owner drops req, RELEASE moves the rr pointer on.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = winner;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        state_d = GRANT;
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        advance = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and owner registers; reset abandons any transaction outright.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Sponge mux and handshake routing; only the owner in GRANT is connected,
  // and reset also forces everything quiet with the sponge held in reset.
  always_comb begin
    grant_active = rst_n && (state_q == GRANT);
    gnt          = '0;
    r_in_ready   = '0;
    r_out_valid  = '0;
    s_rst        = !rst_n || (state_q == FLUSH);
    s_data_in    = '0;
    s_in_valid   = 1'b0;
    s_in_last    = 1'b0;
    s_last_len   = '0;
    s_out_ready  = 1'b0;
    if (grant_active) begin
      gnt[owner_q]         = 1'b1;
      s_data_in            = r_data_in[int'(owner_q)*DATA_IN_BITS +: DATA_IN_BITS];
      s_in_valid           = r_in_valid[owner_q];
      s_in_last            = r_in_last[owner_q];
      s_last_len           = r_last_len[int'(owner_q)*LEN_W +: LEN_W];
      s_out_ready          = r_out_ready[owner_q];
      r_in_ready[owner_q]  = s_in_ready;
      r_out_valid[owner_q] = s_out_valid;
      if (flush_req[owner_q]) begin
        s_rst = 1'b1;
      end
    end
  end

  assign r_data_out = s_data_out;

endmodule

// File: tb/tb_sponge_arbiter.sv
// Self-checking bench for sponge_arbiter with a small behavioural sponge
// stand-in (sum of absorbed words, squeeze word i = sum ^ i*K).
module tb_sponge_arbiter;

  localparam int NREQ  = 4;
  localparam int DIB   = 64;
  localparam int DOB   = 64;
  localparam int LEN_W = $clog2(DIB) + 1;
  localparam logic [63:0] KMUL = 64'h9e3779b97f4a7c15;

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         flush_req;
  logic [NREQ*DIB-1:0]     r_data_in;
  logic [NREQ-1:0]         r_in_valid;
  logic [NREQ-1:0]         r_in_last;
  logic [NREQ*LEN_W-1:0]   r_last_len;
  logic [NREQ-1:0]         r_out_ready;
  logic [NREQ-1:0]         gnt;
  logic [NREQ-1:0]         r_in_ready;
  logic [NREQ-1:0]         r_out_valid;
  logic [DOB-1:0]          r_data_out;
  logic                    s_rst;
  logic [DIB-1:0]          s_data_in;
  logic                    s_in_valid;
  logic                    s_in_last;
  logic [LEN_W-1:0]        s_last_len;
  logic                    s_out_ready;
  logic [DOB-1:0]          s_data_out;
  logic                    s_out_valid;
  logic                    s_in_ready;

  int n_checks;
  int n_pass;
  int model_ptr;

  sponge_arbiter #(
    .NREQ          (NREQ),
    .DATA_IN_BITS  (DIB),
    .DATA_OUT_BITS (DOB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .flush_req   (flush_req),
    .r_data_in   (r_data_in),
    .r_in_valid  (r_in_valid),
    .r_in_last   (r_in_last),
    .r_last_len  (r_last_len),
    .r_out_ready (r_out_ready),
    .gnt         (gnt),
    .r_in_ready  (r_in_ready),
    .r_out_valid (r_out_valid),
    .r_data_out  (r_data_out),
    .s_rst       (s_rst),
    .s_data_in   (s_data_in),
    .s_in_valid  (s_in_valid),
    .s_in_last   (s_in_last),
    .s_last_len  (s_last_len),
    .s_out_ready (s_out_ready),
    .s_data_out  (s_data_out),
    .s_out_valid (s_out_valid),
    .s_in_ready  (s_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural sponge stand-in.
  logic [63:0] sp_acc;
  logic [63:0] sp_ocnt;
  logic        sp_done;
  int          sp_words;

  always @(posedge clk) begin
    if (s_rst) begin
      sp_acc   <= '0;
      sp_ocnt  <= '0;
      sp_done  <= 1'b0;
      sp_words <= 0;
    end else begin
      if (s_in_valid && s_in_ready) begin
        sp_acc   <= sp_acc + s_data_in;
        sp_words <= sp_words + 1;
        if (s_in_last) sp_done <= 1'b1;
      end
      if (s_out_valid && s_out_ready) sp_ocnt <= sp_ocnt + 64'd1;
    end
  end

  assign s_in_ready  = !sp_done;
  assign s_out_valid = sp_done;
  assign s_data_out  = sp_acc ^ (sp_ocnt * KMUL);

  // Reference arbitration rule.
  function automatic int pick(input logic [NREQ-1:0] m, input int p);
`ifdef FIXED_PRIORITY_EN
    for (int i = 0; i < NREQ; i++) if (m[i]) return i;
`else
    for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
`endif
    return 0;
  endfunction

  task automatic clear_inputs();
    req         = '0;
    flush_req   = '0;
    r_data_in   = '0;
    r_in_valid  = '0;
    r_in_last   = '0;
    r_last_len  = '0;
    r_out_ready = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    model_ptr = 0;
  endtask

  task automatic drive_word(input int o, input logic [63:0] w, input logic last);
    r_data_in[o*DIB +: DIB]      = w;
    r_in_valid[o]                = 1'b1;
    r_in_last[o]                 = last;
    r_last_len[o*LEN_W +: LEN_W] = LEN_W'(64);
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n       = 1'b0;
    req         = 4'b1111;
    r_in_valid  = 4'b1111;
    r_out_ready = 4'b1111;
    r_data_in   = {4{64'h0123456789abcdef}};
    r_last_len  = '1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) $display("[TB] FAIL reset_gnt: got %b want 0000", gnt); else n_pass++;
    n_checks++; if (s_rst !== 1'b1) $display("[TB] FAIL reset_s_rst: got %b want 1", s_rst); else n_pass++;
    n_checks++; if (s_in_valid !== 1'b0) $display("[TB] FAIL reset_in_valid: got %b want 0", s_in_valid); else n_pass++;
    n_checks++; if (s_out_ready !== 1'b0) $display("[TB] FAIL reset_out_ready: got %b want 0", s_out_ready); else n_pass++;
    n_checks++; if (s_data_in !== 64'd0) $display("[TB] FAIL reset_data_in: got %h want 0", s_data_in); else n_pass++;
    n_checks++; if (s_last_len !== '0) $display("[TB] FAIL reset_last_len: got %0d want 0", s_last_len); else n_pass++;
    n_checks++; if ((r_in_ready | r_out_valid) !== 4'b0000) $display("[TB] FAIL reset_routing: got %b/%b want 0000", r_in_ready, r_out_valid); else n_pass++;
    clear_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (s_rst !== 1'b0) $display("[TB] FAIL reset_idle_s_rst: got %b want 0", s_rst); else n_pass++;
    n_checks++; if (gnt !== 4'b0000) $display("[TB] FAIL reset_idle_gnt: got %b want 0000", gnt); else n_pass++;
  endtask

  task automatic test_single();
    logic [63:0] w;
    logic [63:0] expv;
    logic        leak;
    do_reset();
    w    = 64'h1234567890abcdef;
    leak = 1'b0;
    req  = 4'b0001;
    @(negedge clk);
    n_checks++; if (s_rst !== 1'b1 || gnt !== 4'b0000) $display("[TB] FAIL single_flush: got s_rst=%b gnt=%b want 1/0000", s_rst, gnt); else n_pass++;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0001 || s_rst !== 1'b0) $display("[TB] FAIL single_grant: got gnt=%b s_rst=%b want 0001/0", gnt, s_rst); else n_pass++;
    drive_word(0, w, 1'b1);
    #1;
    n_checks++; if (s_data_in !== w || s_in_valid !== 1'b1 || s_in_last !== 1'b1) $display("[TB] FAIL single_absorb: got %h v=%b l=%b want %h/1/1", s_data_in, s_in_valid, s_in_last, w); else n_pass++;
    n_checks++; if (s_last_len !== LEN_W'(64)) $display("[TB] FAIL single_last_len: got %0d want 64", s_last_len); else n_pass++;
    n_checks++; if (r_in_ready !== 4'b0001) $display("[TB] FAIL single_in_ready: got %b want 0001", r_in_ready); else n_pass++;
    @(negedge clk);
    r_in_valid = '0;
    r_in_last  = '0;
    for (int i = 0; i < 17; i++) begin
      r_out_ready[0] = 1'b1;
      #1;
      expv = w ^ (64'(i) * KMUL);
      if (((r_in_ready | r_out_valid) & 4'b1110) != 4'b0000) leak = 1'b1;
      n_checks++; if (r_out_valid !== 4'b0001 || r_data_out !== expv) $display("[TB] FAIL single_squeeze_%0d: got v=%b d=%h want 0001/%h", i, r_out_valid, r_data_out, expv); else n_pass++;
      @(negedge clk);
    end
    n_checks++; if (leak !== 1'b0) $display("[TB] FAIL single_nonowner_quiet: got %b want 0", leak); else n_pass++;
    n_checks++; if (sp_words !== 1) $display("[TB] FAIL single_word_count: got %0d want 1", sp_words); else n_pass++;
    r_out_ready = '0;
    req         = '0;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) $display("[TB] FAIL single_release: got %b want 0000", gnt); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int flushes;
    int o;
    bit seen;
    do_reset();
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      flushes = 0;
      seen    = 0;
      for (int c = 0; c < 12 && !seen; c++) begin
        @(negedge clk);
        if (s_rst) flushes++;
        if (gnt != 4'b0000) seen = 1;
      end
      o = pick(req, model_ptr);
      n_checks++; if (!seen || gnt !== (4'b0001 << o)) $display("[TB] FAIL contention_grant_%0d: got %b want %b", g, gnt, 4'b0001 << o); else n_pass++;
      n_checks++; if (flushes !== 1) $display("[TB] FAIL contention_flush_%0d: got %0d want 1", g, flushes); else n_pass++;
      @(negedge clk);
      req[o] = 1'b0;
      @(negedge clk);
      n_checks++; if (gnt !== 4'b0000) $display("[TB] FAIL contention_release_%0d: got %b want 0000", g, gnt); else n_pass++;
      req[o]    = 1'b1;
      model_ptr = (o + 1) % NREQ;
    end
  endtask

  task automatic test_flush_req();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010) $display("[TB] FAIL flush_pre_gnt: got %b want 0010", gnt); else n_pass++;
    flush_req[1] = 1'b1;
    #1;
    n_checks++; if (s_rst !== 1'b1 || gnt !== 4'b0010) $display("[TB] FAIL flush_owner: got s_rst=%b gnt=%b want 1/0010", s_rst, gnt); else n_pass++;
    @(negedge clk);
    flush_req = '0;
    #1;
    n_checks++; if (s_rst !== 1'b0 || gnt !== 4'b0010) $display("[TB] FAIL flush_after: got s_rst=%b gnt=%b want 0/0010", s_rst, gnt); else n_pass++;
    flush_req = 4'b1101;
    #1;
    n_checks++; if (s_rst !== 1'b0) $display("[TB] FAIL flush_nonowner: got %b want 0", s_rst); else n_pass++;
    @(negedge clk);
    flush_req = '0;
  endtask

  task automatic test_nonowner_data();
    logic [63:0] w;
    do_reset();
    w   = {$urandom, $urandom};
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0100) $display("[TB] FAIL nonowner_gnt: got %b want 0100", gnt); else n_pass++;
    r_data_in[0 +: DIB] = 64'hdeadbeef;
    r_in_valid[0]       = 1'b1;
    drive_word(2, w, 1'b0);
    #1;
    n_checks++; if (s_data_in !== w) $display("[TB] FAIL nonowner_mux: got %h want %h", s_data_in, w); else n_pass++;
    n_checks++; if (r_in_ready !== 4'b0100) $display("[TB] FAIL nonowner_in_ready: got %b want 0100", r_in_ready); else n_pass++;
    @(negedge clk);
    r_in_valid[2] = 1'b0;
    #1;
    n_checks++; if (s_in_valid !== 1'b0) $display("[TB] FAIL nonowner_valid_leak: got %b want 0", s_in_valid); else n_pass++;
    @(negedge clk);
    n_checks++; if (sp_words !== 1 || sp_acc !== w) $display("[TB] FAIL nonowner_words: got %0d/%h want 1/%h", sp_words, sp_acc, w); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_reset_mid_squeeze();
    do_reset();
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    drive_word(0, 64'h55aa55aa00ff00ff, 1'b1);
    @(negedge clk);
    r_in_valid     = '0;
    r_out_ready[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000 || s_rst !== 1'b1 || s_out_ready !== 1'b0 || r_out_valid !== 4'b0000) $display("[TB] FAIL midreset_abort: got gnt=%b s_rst=%b ordy=%b ov=%b want 0000/1/0/0000", gnt, s_rst, s_out_ready, r_out_valid); else n_pass++;
    clear_inputs();
    rst_n = 1'b1;
    req   = 4'b0100;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000 || s_rst !== 1'b1) $display("[TB] FAIL midreset_flush: got gnt=%b s_rst=%b want 0000/1", gnt, s_rst); else n_pass++;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0100) $display("[TB] FAIL midreset_regrant: got %b want 0100", gnt); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_flush_drop();
    int o;
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    n_checks++; if (s_rst !== 1'b1 || gnt !== 4'b0000) $display("[TB] FAIL drop_flush: got s_rst=%b gnt=%b want 1/0000", s_rst, gnt); else n_pass++;
    req = 4'b0000;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0010) $display("[TB] FAIL drop_short_grant: got %b want 0010", gnt); else n_pass++;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) $display("[TB] FAIL drop_release: got %b want 0000", gnt); else n_pass++;
    model_ptr = 2;
    req       = 4'b0110;
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000 || s_rst !== 1'b0) $display("[TB] FAIL drop_idle: got gnt=%b s_rst=%b want 0000/0", gnt, s_rst); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    o = pick(4'b0110, model_ptr);
    n_checks++; if (gnt !== (4'b0001 << o)) $display("[TB] FAIL drop_ptr_advance: got %b want %b", gnt, 4'b0001 << o); else n_pass++;
    clear_inputs();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] mask;
    logic [63:0]     w;
    logic [63:0]     sum;
    logic [63:0]     expv;
    int              o;
    int              nw;
    do_reset();
    for (int it = 0; it < 16; it++) begin
      mask = NREQ'($urandom_range(1, 15));
      req  = mask;
      @(negedge clk);
      n_checks++; if (s_rst !== 1'b1 || gnt !== 4'b0000) $display("[TB] FAIL rand_flush_%0d: got s_rst=%b gnt=%b want 1/0000", it, s_rst, gnt); else n_pass++;
      @(negedge clk);
      o = pick(mask, model_ptr);
      n_checks++; if (gnt !== (4'b0001 << o)) $display("[TB] FAIL rand_grant_%0d: got %b want %b (mask %b)", it, gnt, 4'b0001 << o, mask); else n_pass++;
      nw  = $urandom_range(1, 3);
      sum = '0;
      for (int k = 0; k < nw; k++) begin
        for (int j = 0; j < NREQ; j++) begin
          r_data_in[j*DIB +: DIB] = {$urandom, $urandom};
          r_in_valid[j]           = 1'($urandom_range(0, 1));
        end
        w   = {$urandom, $urandom};
        sum = sum + w;
        drive_word(o, w, (k == nw - 1));
        #1;
        n_checks++; if (s_data_in !== w || r_in_ready !== (4'b0001 << o)) $display("[TB] FAIL rand_absorb_%0d_%0d: got %h rdy=%b want %h", it, k, s_data_in, r_in_ready, w); else n_pass++;
        @(negedge clk);
        r_in_valid = '0;
        r_in_last  = '0;
      end
      n_checks++; if (sp_words !== nw) $display("[TB] FAIL rand_words_%0d: got %0d want %0d", it, sp_words, nw); else n_pass++;
      for (int i = 0; i < 2; i++) begin
        r_out_ready = 4'b1111;
        #1;
        expv = sum ^ (64'(i) * KMUL);
        n_checks++; if (r_out_valid !== (4'b0001 << o) || r_data_out !== expv) $display("[TB] FAIL rand_squeeze_%0d_%0d: got v=%b d=%h want %h", it, i, r_out_valid, r_data_out, expv); else n_pass++;
        @(negedge clk);
      end
      clear_inputs();
      @(negedge clk);
      n_checks++; if (gnt !== 4'b0000) $display("[TB] FAIL rand_release_%0d: got %b want 0000", it, gnt); else n_pass++;
      @(negedge clk);
      model_ptr = (o + 1) % NREQ;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_flush_req();
    test_nonowner_data();
    test_reset_mid_squeeze();
    test_flush_drop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
